// File: rtl/xterm_tty.sv
// xterm_tty: 8N1 UART endpoint with a synchronized receiver on TX_in and a transmitter on RX_out.
// Optional feature: define XTERM_TTY_ECHO_EN to retransmit every correctly received byte.
module xterm_tty #(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic       clock_50,
    input  logic       reset_n,
    input  logic       TX_in,
    output logic       RX_out,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready
);
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DATA_W = 8;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [1:0]        sync_q;
    logic              rx_line;
    state_t            rx_state, rx_state_nxt;
    logic [CNT_W-1:0]  rx_cnt, rx_cnt_nxt;
    logic [2:0]        rx_bit, rx_bit_nxt;
    logic [DATA_W-1:0] rx_sh, rx_sh_nxt, rx_data_nxt;
    logic              rx_valid_nxt, rx_err_nxt;

    state_t            tx_state, tx_state_nxt;
    logic [CNT_W-1:0]  tx_cnt, tx_cnt_nxt;
    logic [2:0]        tx_bit, tx_bit_nxt;
    logic [DATA_W-1:0] tx_sh, tx_sh_nxt, tx_load_c;
    logic              tx_line_nxt, tx_ready_nxt, tx_start_c;
`ifdef XTERM_TTY_ECHO_EN
    logic              echo_full, echo_full_nxt;
    logic [DATA_W-1:0] echo_byte, echo_byte_nxt;
`endif

    assign rx_line = sync_q[1];

    // Receiver: detect start, confirm at half bit, then sample at bit midpoints.
    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_bit_nxt   = rx_bit;
        rx_sh_nxt    = rx_sh;
        rx_data_nxt  = rx_data;
        rx_valid_nxt = 1'b0;
        rx_err_nxt   = 1'b0;
        case (rx_state)
            S_IDLE: begin
                if (!rx_line) begin
                    rx_state_nxt = S_START;
                    rx_cnt_nxt   = '0;
                end
            end
            S_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_bit_nxt   = '0;
                    rx_state_nxt = rx_line ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_nxt = rx_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt = '0;
                    rx_sh_nxt  = {rx_line, rx_sh[DATA_W-1:1]};
                    if (rx_bit == 3'd7) begin
                        rx_state_nxt = S_STOP;
                    end else begin
                        rx_bit_nxt = rx_bit + 3'd1;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_state_nxt = S_IDLE;
                    if (rx_line) begin
                        rx_data_nxt  = rx_sh;
                        rx_valid_nxt = 1'b1;
                    end else begin
                        rx_err_nxt = 1'b1;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt + CNT_W'(1);
                end
            end
            default: rx_state_nxt = S_IDLE;
        endcase
    end

    // Transmitter: echo (when enabled) wins over the tx_data/tx_valid handshake.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_bit_nxt   = tx_bit;
        tx_sh_nxt    = tx_sh;
        tx_line_nxt  = RX_out;
        tx_load_c    = tx_data;
        tx_start_c   = (tx_state == S_IDLE) && tx_valid && tx_ready;
`ifdef XTERM_TTY_ECHO_EN
        echo_full_nxt = echo_full;
        echo_byte_nxt = echo_byte;
        if (echo_full) begin
            tx_start_c = (tx_state == S_IDLE);
            tx_load_c  = echo_byte;
            if (tx_state == S_IDLE) begin
                echo_full_nxt = 1'b0;
            end
        end
        if (rx_valid_nxt) begin
            echo_full_nxt = 1'b1;
            echo_byte_nxt = rx_data_nxt;
        end
`endif
        case (tx_state)
            S_IDLE: begin
                if (tx_start_c) begin
                    tx_sh_nxt    = tx_load_c;
                    tx_line_nxt  = 1'b0;
                    tx_cnt_nxt   = '0;
                    tx_state_nxt = S_START;
                end
            end
            S_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt   = '0;
                    tx_bit_nxt   = '0;
                    tx_line_nxt  = tx_sh[0];
                    tx_sh_nxt    = {1'b0, tx_sh[DATA_W-1:1]};
                    tx_state_nxt = S_DATA;
                end else begin
                    tx_cnt_nxt = tx_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt = '0;
                    if (tx_bit == 3'd7) begin
                        tx_line_nxt  = 1'b1;
                        tx_state_nxt = S_STOP;
                    end else begin
                        tx_line_nxt = tx_sh[0];
                        tx_sh_nxt   = {1'b0, tx_sh[DATA_W-1:1]};
                        tx_bit_nxt  = tx_bit + 3'd1;
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt   = '0;
                    tx_state_nxt = S_IDLE;
                end else begin
                    tx_cnt_nxt = tx_cnt + CNT_W'(1);
                end
            end
            default: tx_state_nxt = S_IDLE;
        endcase
`ifdef XTERM_TTY_ECHO_EN
        tx_ready_nxt = (tx_state_nxt == S_IDLE) && !echo_full_nxt;
`else
        tx_ready_nxt = (tx_state_nxt == S_IDLE);
`endif
    end

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync_q       <= '1;
            rx_state     <= S_IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_sh        <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            tx_state     <= S_IDLE;
            tx_cnt       <= '0;
            tx_bit       <= '0;
            tx_sh        <= '0;
            RX_out       <= 1'b1;
            tx_ready     <= 1'b0;
`ifdef XTERM_TTY_ECHO_EN
            echo_full    <= 1'b0;
            echo_byte    <= '0;
`endif
        end else begin
            sync_q       <= {sync_q[0], TX_in};
            rx_state     <= rx_state_nxt;
            rx_cnt       <= rx_cnt_nxt;
            rx_bit       <= rx_bit_nxt;
            rx_sh        <= rx_sh_nxt;
            rx_data      <= rx_data_nxt;
            rx_valid     <= rx_valid_nxt;
            rx_frame_err <= rx_err_nxt;
            tx_state     <= tx_state_nxt;
            tx_cnt       <= tx_cnt_nxt;
            tx_bit       <= tx_bit_nxt;
            tx_sh        <= tx_sh_nxt;
            RX_out       <= tx_line_nxt;
            tx_ready     <= tx_ready_nxt;
`ifdef XTERM_TTY_ECHO_EN
            echo_full    <= echo_full_nxt;
            echo_byte    <= echo_byte_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_xterm_tty.sv
// Self-checking bench for xterm_tty (BAUD_DIV = 16): serial frames are built and decoded from
// the 8N1 rules directly; a byte queue scoreboard holds the expected receive stream.
module tb_xterm_tty;
    localparam int unsigned BAUD = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       TX_in;
    logic       RX_out;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    int last_valid_cyc = 0;
    int rx_t0 = 0;
    int last_wait = 0;
    int exp_valid = 0;
    int exp_ferr = 0;
    logic [7:0] exp_data = 8'h00;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    xterm_tty #(.BAUD_DIV(BAUD)) dut (
        .clock_50    (clk),
        .reset_n     (rst_n),
        .TX_in       (TX_in),
        .RX_out      (RX_out),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts every cycle a pulse output is high and logs delivered bytes.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            got_q.push_back(rx_data);
        end
        if (rx_frame_err === 1'b1) ferr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Drive one 8N1 frame onto TX_in, LSB first.
    task automatic send_serial(input logic [7:0] b, input logic stop);
        TX_in = 1'b0;
        rx_t0 = cyc;
        tick(BAUD);
        for (int i = 0; i < 8; i++) begin
            TX_in = b[i];
            tick(BAUD);
        end
        TX_in = stop;
        tick(BAUD);
        TX_in = 1'b1;
    endtask

    // Wait for a start bit on RX_out, sample all ten bits at mid-bit, and time tx_ready low.
    task automatic capture(input logic noise, input logic [7:0] exp_b, input string tag);
        int n;
        logic [9:0] bits;
        logic [9:0] exp_bits;
        n = 0;
        while (RX_out !== 1'b0 && n < 400) begin
            tick(1);
            n++;
        end
        chk({tag, "_start_seen"}, 32'(n < 400), 32'd1);
        chk({tag, "_ready_low"}, 32'(tx_ready), 32'd0);
        n = 0;
        bits = '1;
        while (tx_ready !== 1'b1 && n < 400) begin
            if ((n % 16) == 8 && n < 160) bits[n / 16] = RX_out;
            if (noise) begin
                tx_valid = (n < 150) ? 1'($urandom % 2) : 1'b0;
                tx_data  = 8'($urandom);
            end
            tick(1);
            n++;
        end
        tx_valid = 1'b0;
        exp_bits = {1'b1, exp_b, 1'b0};
        chk({tag, "_busy_cycles"}, n, 160);
        chk({tag, "_frame_bits"}, 32'(bits), 32'(exp_bits));
        chk({tag, "_line_idle"}, 32'(RX_out), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic noise, input string tag);
        int n;
        n = 0;
        while (tx_ready !== 1'b1 && n < 1000) begin
            tick(1);
            n++;
        end
        last_wait = n;
        tx_data  = b;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        capture(noise, b, tag);
    endtask

    // Expected receive outcome for one frame, from the stop bit alone.
    task automatic expect_rx(input logic [7:0] b, input logic stop);
        if (stop) begin
            exp_valid++;
            exp_data = b;
            exp_q.push_back(b);
        end else begin
            exp_ferr++;
        end
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_valid_cnt"}, valid_cnt, exp_valid);
        chk({tag, "_ferr_cnt"}, ferr_cnt, exp_ferr);
        chk({tag, "_rx_data"}, 32'(rx_data), 32'(exp_data));
    endtask

    initial begin
        logic [7:0] b;
        logic       s;
        TX_in    = 1'b1;
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tick(3);
        chk("rst_rx_out", 32'(RX_out), 32'd1);
        chk("rst_tx_ready", 32'(tx_ready), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_frame_err", 32'(rx_frame_err), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'h00);
        rst_n = 1'b1;
        tick(1);
        chk("ready_after_rst", 32'(tx_ready), 32'd1);

`ifdef XTERM_TTY_ECHO_EN
        fork
            send_serial(8'h41, 1'b1);
            capture(1'b0, 8'h41, "echo");
        join
        expect_rx(8'h41, 1'b1);
        check_rx("echo_rx");
        tick(5);
        chk("echo_ready_after", 32'(tx_ready), 32'd1);
`else
        send_serial(8'hA5, 1'b1);
        expect_rx(8'hA5, 1'b1);
        check_rx("rx_a5");
        chk("rx_a5_latency", 32'((last_valid_cyc - rx_t0) >= 150 && (last_valid_cyc - rx_t0) <= 165), 32'd1);
        tick(20);
        chk("rx_a5_single_pulse", valid_cnt, exp_valid);

        send_serial(8'h3C, 1'b0);
        expect_rx(8'h3C, 1'b0);
        tick(30);
        check_rx("rx_bad_stop");

        TX_in = 1'b0;
        tick(6);
        TX_in = 1'b1;
        tick(40);
        check_rx("rx_glitch");
        send_serial(8'h5A, 1'b1);
        expect_rx(8'h5A, 1'b1);
        tick(5);
        check_rx("rx_after_glitch");

        send_serial(8'h81, 1'b1);
        expect_rx(8'h81, 1'b1);
        send_serial(8'h7E, 1'b1);
        expect_rx(8'h7E, 1'b1);
        tick(5);
        check_rx("rx_back_to_back");

        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            s = 1'(($urandom % 4) != 0);
            send_serial(b, s);
            expect_rx(b, s);
            tick(30 + int'($urandom % 10));
            check_rx("rx_random");
        end

        send_byte(8'h4B, 1'b0, "tx_4b");
        chk("tx_4b_no_rx_side_effect", valid_cnt, exp_valid);
        send_byte(8'hC3, 1'b1, "tx_noise");
        send_byte(8'h18, 1'b0, "tx_b2b");
        chk("tx_b2b_gap", last_wait, 0);
        for (int i = 0; i < 3; i++) begin
            send_byte(8'($urandom), 1'b1, "tx_random");
        end

        tx_data  = 8'h00;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tick(8 + 16 * 5);
        chk("tx_mid_bit4_low", 32'(RX_out), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("tx_abort_rx_out", 32'(RX_out), 32'd1);
        chk("tx_abort_ready", 32'(tx_ready), 32'd0);
        exp_data = 8'h00;
        chk("tx_abort_rx_data", 32'(rx_data), 32'(exp_data));
        tick(3);
        rst_n = 1'b1;
        tick(1);
        chk("tx_abort_ready_release", 32'(tx_ready), 32'd1);
        tick(200);
        chk("tx_abort_line_idle", 32'(RX_out), 32'd1);

        TX_in = 1'b0;
        tick(70);
        rst_n = 1'b0;
        TX_in = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(200);
        check_rx("rx_abort");

        chk("sb_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk("sb_byte", 32'(got_q[i]), 32'(exp_q[i]));
        end
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/xterm_tty.md
XTERM_TTY -- requirements
Module: xterm_tty

Interface
REQ-001 Parameter: BAUD_DIV, default 434, clock cycles per UART bit (50 MHz / 115200); legal range 8..65535.
REQ-002 Port: clock_50  in  1  system clock; all logic on rising edge.
REQ-003 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-004 Port: TX_in  in  1  serial line from the UART transmitter of the attached design; idle high.
REQ-005 Port: RX_out  out  1  serial line to the UART receiver of the attached design; idle high.
REQ-006 Port: rx_data  out  8  last correctly received byte.
REQ-007 Port: rx_valid  out  1  one-cycle pulse when rx_data updates.
REQ-008 Port: rx_frame_err  out  1  one-cycle pulse on a bad stop bit.
REQ-009 Port: tx_data  in  8  byte to send on RX_out.
REQ-010 Port: tx_valid  in  1  request to send tx_data.
REQ-011 Port: tx_ready  out  1  high when the transmitter accepts a byte this cycle.

Function
REQ-012 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1, each bit BAUD_DIV cycles.
REQ-013 TX_in SHALL pass through a 2-flop synchronizer before any use.
REQ-014 Receiver states SHALL be IDLE, START, DATA, STOP.
- IDLE -> START on synchronized TX_in = 0.
REQ-015 START SHALL resample at BAUD_DIV/2 cycles.
- 0 -> DATA; 1 -> IDLE (glitch rejected, no pulse).
REQ-016 DATA SHALL sample each bit every BAUD_DIV cycles from the start-bit midpoint; after 8 bits -> STOP.
REQ-017 STOP SHALL sample once BAUD_DIV cycles later.
- 1: rx_data updates and rx_valid pulses the next cycle.
- 0: rx_frame_err pulses and rx_data is unchanged.
- Either case -> IDLE.
REQ-018 A start bit arriving immediately after the stop sample SHALL be received back-to-back with no lost frame.
REQ-019 Transmitter states SHALL be IDLE, START, DATA, STOP.
- tx_ready = 1 only in IDLE.
- tx_valid & tx_ready latches tx_data, then START.
REQ-020 The transmitter SHALL drive RX_out from a register: start 0, data LSB first, stop 1, each BAUD_DIV cycles.
- After the stop bit: IDLE, tx_ready high on the following cycle.
REQ-021 Back-to-back frames (tx_valid held high) SHALL be separated only by the one IDLE cycle.
REQ-022 tx_data and tx_valid SHALL be ignored while tx_ready = 0; the frame in progress is never corrupted.
REQ-023 Bit counters SHALL be 16 bits wide and wrap only at BAUD_DIV-1 back to 0.

Reset
REQ-024 While reset_n = 0:
- RX_out = 1, tx_ready = 0, rx_valid = 0, rx_frame_err = 0, rx_data = 8'h00.
- Both state machines in IDLE; synchronizer flops = 1.
REQ-025 tx_ready SHALL rise on the first clock edge after reset_n deasserts.
REQ-026 Reset asserted mid-frame SHALL abort both directions immediately.
- RX_out returns to 1; no rx_valid for the partial frame.

Configuration
REQ-027 Macro XTERM_TTY_ECHO_EN defined: every byte that produces rx_valid SHALL be queued in a 1-entry echo register and retransmitted on RX_out.
- Echo has priority over tx_valid: tx_ready = 0 while the echo register is full.
- A new echo while the register is full overwrites it (last byte wins).
REQ-028 Macro not defined: no echo logic; the transmitter is driven only by tx_data/tx_valid.

Verification
REQ-029 BAUD_DIV = 16; frame 0xA5 on TX_in (stop = 1) -> rx_data = 0xA5, one rx_valid pulse about 160 cycles after the start edge.
REQ-030 BAUD_DIV = 16; tx_valid with 0x4B -> RX_out sequence 0,1,1,0,1,0,0,1,0,1, 16 cycles per bit; tx_ready low for 160 cycles, high 1 cycle after.
REQ-031 Frame 0x3C with stop bit 0 -> rx_frame_err pulses once, rx_valid stays 0, rx_data keeps its previous value.
REQ-032 6-cycle low glitch on TX_in (BAUD_DIV = 16) -> no rx_valid, no rx_frame_err; receiver back in IDLE.
REQ-033 reset_n low at bit 4 of a TX frame -> RX_out = 1 and tx_ready = 0 immediately; tx_ready = 1 one cycle after release.
REQ-034 With XTERM_TTY_ECHO_EN: receive 0x41 -> 0x41 retransmitted on RX_out; tx_ready = 0 until the echo frame completes.
